// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared constants and types for the pong video path: screen geometry,
// coordinate and colour widths, the scanner state encoding and the tag that
// travels with a query through the render pipeline.
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int SCREEN_W = 160;  // pixels per row
    localparam int SCREEN_H = 120;  // pixels per column
    localparam int X_W      = 8;    // column coordinate width
    localparam int Y_W      = 7;    // row coordinate width
    localparam int COLOUR_W = 3;    // VGA adapter colour width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } scan_state_t;

    // Query coordinates, tagged with validity and end-of-frame, one cycle
    // after issue while the renderer works out the colour.
    typedef struct packed {
        logic           valid;
        logic           last;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_tag_t;

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column/row raster counter. The row is the inner (fast) coordinate, the column
// the outer one. Advancing from the last pixel wraps back to (0,0), so the
// counter rests at the origin whenever it is not advancing.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, clears to (0,0)
//   i_advance  step to the next pixel this cycle
//   o_x, o_y   current column / row
//   o_last     current position is the final pixel (W-1, H-1)
// -----------------------------------------------------------------------------
module raster_counter #(
    parameter int W = pong_pkg::SCREEN_W,
    parameter int H = pong_pkg::SCREEN_H
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_advance,
    output logic [pong_pkg::X_W-1:0] o_x,
    output logic [pong_pkg::Y_W-1:0] o_y,
    output logic                     o_last
);
    import pong_pkg::*;

    localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_row_end;
    logic           w_last;

    assign w_row_end = (r_y == Y_LAST);
    assign w_last    = w_row_end && (r_x == X_LAST);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation races and can mismatch the synthesised netlist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_last) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_row_end) begin
                r_x <= r_x + X_W'(1);
                r_y <= '0;
            end else begin
                r_y <= r_y + Y_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_last;

endmodule

// File: rtl/pixel_scanner.sv
// -----------------------------------------------------------------------------
// pixel_scanner
// Walks every screen pixel once per frame, asks the renderer for its colour and
// writes it to the VGA adapter. A frame is SCAN (one query per cycle), DRAIN
// (two cycles to flush the pipeline) and GAP (GAP_CYCLES cycles during which
// game state may be updated). GAP_CYCLES must be at least 1.
//
// Ports
//   CLOCK_50       clock, rising edge
//   resetn         asynchronous active-low reset
//   enable         allows a new frame to start (from IDLE or at end of GAP)
//   query_x/_y     pixel presented to the renderer this cycle
//   pix_colour     renderer answer for the previous cycle's query
//   x, y, colour   VGA adapter write data (zero when plot is low)
//   plot           VGA adapter write strobe
//   frame_start    pulse in the first SCAN cycle
//   frame_done     pulse with the final plot of a frame
//   update_window  high in every GAP cycle
//   frame_count    completed frames, wraps at 256
// -----------------------------------------------------------------------------
module pixel_scanner #(
    parameter int SCREEN_W   = pong_pkg::SCREEN_W,
    parameter int SCREEN_H   = pong_pkg::SCREEN_H,
    parameter int GAP_CYCLES = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          enable,
    output logic [pong_pkg::X_W-1:0]      query_x,
    output logic [pong_pkg::Y_W-1:0]      query_y,
    input  logic [pong_pkg::COLOUR_W-1:0] pix_colour,
    output logic [pong_pkg::X_W-1:0]      x,
    output logic [pong_pkg::Y_W-1:0]      y,
    output logic [pong_pkg::COLOUR_W-1:0] colour,
    output logic                          plot,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          update_window,
    output logic [7:0]                    frame_count
);
    import pong_pkg::*;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    scan_state_t         r_state;
    logic                r_drain;        // 0 = first DRAIN cycle, 1 = second
    logic [GAP_W-1:0]    r_gap;
    logic                r_frame_start;
    logic                r_update_window;

    logic [X_W-1:0]      w_query_x;
    logic [Y_W-1:0]      w_query_y;
    logic                w_last;
    logic                w_scanning;

    pix_tag_t            r_s1;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_frame_done;
    logic [7:0]          r_frame_count;

    assign w_scanning = (r_state == SCAN);

    raster_counter #(
        .W (SCREEN_W),
        .H (SCREEN_H)
    ) u_raster (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .i_advance (w_scanning),
        .o_x       (w_query_x),
        .o_y       (w_query_y),
        .o_last    (w_last)
    );

    // Frame sequencer. frame_start and update_window are registered alongside
    // the state so they line up exactly with the SCAN / GAP cycles.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state         <= IDLE;
            r_drain         <= 1'b0;
            r_gap           <= '0;
            r_frame_start   <= 1'b0;
            r_update_window <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state       <= SCAN;
                        r_frame_start <= 1'b1;
                    end
                end
                SCAN: begin
                    // enable is ignored here: a started frame always completes.
                    if (w_last) begin
                        r_state <= DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (r_drain) begin
                        r_state         <= GAP;
                        r_gap           <= '0;
                        r_update_window <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_update_window <= 1'b0;
                        if (enable) begin
                            r_state       <= SCAN;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-stage render pipeline: stage 1 holds the query while the renderer
    // answers, stage 2 captures that answer and drives the adapter.
    // NOTE: the pipeline registers are reset too, so a reset mid-frame drops
    // any in-flight pixels instead of plotting stale data after release.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_s1          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_colour      <= '0;
            r_plot        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_s1.valid <= w_scanning;
            r_s1.last  <= w_scanning && w_last;
            r_s1.x     <= w_query_x;
            r_s1.y     <= w_query_y;

            r_plot       <= r_s1.valid;
            r_frame_done <= r_s1.last;
            r_x          <= r_s1.valid ? r_s1.x     : '0;
            r_y          <= r_s1.valid ? r_s1.y     : '0;
            r_colour     <= r_s1.valid ? pix_colour : '0;

            if (r_frame_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign query_x       = w_query_x;
    assign query_y       = w_query_y;
    assign x             = r_x;
    assign y             = r_y;
    assign colour        = r_colour;
    assign plot          = r_plot;
    assign frame_start   = r_frame_start;
    assign frame_done    = r_frame_done;
    assign update_window = r_update_window;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_pixel_scanner.sv
// -----------------------------------------------------------------------------
// tb_pixel_scanner
// Two scanners share one clock: instance 0 at default geometry, instance 1 at
// 4x3 with a one-cycle gap. The reference model tracks, per instance, whether a
// frame is running and the cycle index k since its frame_start, and derives
// every expected output from k with plain arithmetic.
// Output bundle layout (45 bits):
//   [44:37] query_x [36:30] query_y [29:22] x [21:15] y [14:12] colour
//   [11] plot [10] frame_start [9] frame_done [8] update_window [7:0] frame_count
// -----------------------------------------------------------------------------
module tb_pixel_scanner;

    logic       clk = 1'b0;
    logic [1:0] rstn;
    logic [1:0] en;
    logic [2:0] pix [2];

    logic [7:0] qx0, x0, fc0, qx1, x1, fc1;
    logic [6:0] qy0, y0, qy1, y1;
    logic [2:0] col0, col1;
    logic       plot0, fs0, fd0, uw0, plot1, fs1, fd1, uw1;

    always #10 clk = ~clk;

    pixel_scanner u_dut0 (
        .CLOCK_50 (clk), .resetn (rstn[0]), .enable (en[0]),
        .query_x (qx0), .query_y (qy0), .pix_colour (pix[0]),
        .x (x0), .y (y0), .colour (col0), .plot (plot0),
        .frame_start (fs0), .frame_done (fd0), .update_window (uw0),
        .frame_count (fc0)
    );

    pixel_scanner #(.SCREEN_W(4), .SCREEN_H(3), .GAP_CYCLES(1)) u_dut1 (
        .CLOCK_50 (clk), .resetn (rstn[1]), .enable (en[1]),
        .query_x (qx1), .query_y (qy1), .pix_colour (pix[1]),
        .x (x1), .y (y1), .colour (col1), .plot (plot1),
        .frame_start (fs1), .frame_done (fd1), .update_window (uw1),
        .frame_count (fc1)
    );

    wire [44:0] got0 = {qx0, qy0, x0, y0, col0, plot0, fs0, fd0, uw0, fc0};
    wire [44:0] got1 = {qx1, qy1, x1, y1, col1, plot1, fs1, fd1, uw1, fc1};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int p_w(input int i); return (i == 0) ? 160 : 4;  endfunction
    function automatic int p_h(input int i); return (i == 0) ? 120 : 3;  endfunction
    function automatic int p_g(input int i); return (i == 0) ? 16  : 1;  endfunction
    function automatic int p_len(input int i); return p_w(i) * p_h(i) + 2 + p_g(i); endfunction

    // Reference model state
    bit         m_run  [2];
    int         m_k    [2];
    int         m_cnt  [2];
    bit         m_done [2];
    logic [2:0] m_col  [2];
    logic [44:0] m_exp [2];

    // Bench bookkeeping
    int         cyc = 0;
    int         rmode = 0;       // 0: colour = previous query_x[2:0], 1: random
    logic [7:0] last_qx [2];
    int         plot_cnt [2];
    int         uw_run [2];
    int         start0 [$];
    int         start1 [$];
    logic [7:0] prev_fc1 = '0;
    bit         wrapped = 1'b0;

    function automatic logic [44:0] expect_outs(input int i);
        int wh, k, qx, qy, px, py;
        logic pl, fs, fd, uw;
        logic [2:0] c;
        wh = p_w(i) * p_h(i);
        k  = m_k[i];
        qx = 0; qy = 0; px = 0; py = 0; c = '0;
        if (m_run[i] && k < wh) begin
            qx = k / p_h(i);
            qy = k % p_h(i);
        end
        pl = m_run[i] && (k >= 2) && (k < wh + 2);
        if (pl) begin
            px = (k - 2) / p_h(i);
            py = (k - 2) % p_h(i);
            c  = m_col[i];
        end
        fs = m_run[i] && (k == 0);
        fd = m_run[i] && (k == wh + 1);
        uw = m_run[i] && (k >= wh + 2);
        return {8'(qx), 7'(qy), 8'(px), 7'(py), c, pl, fs, fd, uw, 8'(m_cnt[i])};
    endfunction

    task automatic model_reset(input int i);
        m_run[i] = 1'b0; m_k[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0; m_col[i] = '0;
        plot_cnt[i] = 0; uw_run[i] = 0; last_qx[i] = '0;
        m_exp[i] = expect_outs(i);
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step(input int i);
        if (!rstn[i]) begin
            model_reset(i);
        end else begin
            if (m_done[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
            if (!m_run[i]) begin
                if (en[i]) begin
                    m_run[i] = 1'b1;
                    m_k[i]   = 0;
                end
            end else begin
                m_k[i]++;
                if (m_k[i] == p_len(i)) begin
                    m_k[i] = 0;
                    if (!en[i]) m_run[i] = 1'b0;
                end
            end
            m_col[i]  = pix[i];
            m_exp[i]  = expect_outs(i);
            m_done[i] = m_exp[i][9];
        end
    endtask

    task automatic cycle();
        logic [44:0] g;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? got0 : got1;
            check((i == 0) ? "outs0" : "outs1", 64'(g), 64'(m_exp[i]));
            if (g[10]) begin
                if (i == 0) start0.push_back(cyc);
                else        start1.push_back(cyc);
            end
            if (g[11]) plot_cnt[i]++;
            if (g[9]) begin
                check("plots_per_frame", 64'(plot_cnt[i]), 64'(p_w(i) * p_h(i)));
                check("done_xy", 64'({g[29:22], g[21:15]}), 64'({8'(p_w(i) - 1), 7'(p_h(i) - 1)}));
                plot_cnt[i] = 0;
            end
            if (g[8]) begin
                uw_run[i]++;
            end else if (uw_run[i] != 0) begin
                check("gap_len", 64'(uw_run[i]), 64'(p_g(i)));
                uw_run[i] = 0;
            end
            if (i == 1) begin
                if (prev_fc1 == 8'd255 && g[7:0] == 8'd0) wrapped = 1'b1;
                prev_fc1 = g[7:0];
            end
            // Renderer: answer for the query issued in the cycle before this one.
            pix[i]     = (rmode == 0) ? last_qx[i][2:0] : 3'($urandom);
            last_qx[i] = m_exp[i][44:37];
        end
    endtask

    initial begin
        rstn = 2'b00;
        en   = 2'b00;
        pix[0] = '0;
        pix[1] = '0;
        for (int i = 0; i < 2; i++) model_reset(i);

        // Reset state
        repeat (3) cycle();
        check("rst_fc0", 64'(fc0), 64'd0);
        check("rst_plot0", 64'(plot0), 64'd0);

        // Phase A: frame start latency, three frames, enable dropped in frame 3
        rstn = 2'b11;
        en   = 2'b01;
        cycle();
        check("first_fs", 64'(fs0), 64'd1);
        check("first_query", 64'({qx0, qy0}), 64'd0);
        cycle();
        check("second_query", 64'({qx0, qy0}), 64'({8'd0, 7'd1}));
        cycle();
        check("first_plot", 64'({plot0, x0, y0}), 64'({1'b1, 8'd0, 7'd0}));
        repeat (2 * p_len(0) + 5000 - 3) cycle();
        en[0] = 1'b0;
        repeat (p_len(0) - 5000 + 50) cycle();
        check("frames_started", 64'(start0.size()), 64'd3);
        if (start0.size() >= 3) begin
            check("period_1", 64'(start0[1] - start0[0]), 64'(p_len(0)));
            check("period_2", 64'(start0[2] - start0[1]), 64'(p_len(0)));
        end
        check("frame_count_3", 64'(fc0), 64'd3);

        // Phase B: random colours, reset pulsed mid-frame
        rmode = 1;
        en[0] = 1'b1;
        repeat (7001) cycle();
        rstn[0] = 1'b0;
        #1;
        model_reset(0);
        check("async_rst", 64'(got0), 64'(m_exp[0]));
        check("async_rst_fc", 64'(fc0), 64'd0);
        repeat (3) cycle();
        rstn[0] = 1'b1;
        cycle();
        check("restart_fs", 64'(fs0), 64'd1);
        check("restart_query", 64'({qx0, qy0}), 64'd0);
        repeat (300) cycle();
        rstn[0] = 1'b0;
        en[0]   = 1'b0;
        cycle();

        // Phase C: small screen, 256 frames, frame_count wrap
        rmode = 0;
        en[1] = 1'b1;
        repeat (256 * p_len(1)) cycle();
        en[1] = 1'b0;
        repeat (5) cycle();
        check("small_frames", 64'(start1.size()), 64'd256);
        check("fc_wrapped", 64'(wrapped), 64'd1);
        check("fc_after_256", 64'(fc1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
